// File: rtl/seg_day_decoder.sv
// Weekday recovery from second-letter 7-segment glyphs: debounce, context decode, lock.
// Optional SEG_DEC_ERRCNT_EN adds a saturating err_count output.
module seg_day_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int LOCK_COUNT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic       sym_strobe,
    output logic [2:0] day,
    output logic       day_valid,
    output logic       locked,
    output logic       err
`ifdef SEG_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
    localparam logic [2:0] LOCKN  = 3'(LOCK_COUNT);

    state_t     state;
    logic [6:0] seg_q;
    logic [6:0] cand;
    logic [6:0] last_sym;
    logic [3:0] cnt;
    logic [2:0] match;

    logic       acc;
    logic       known;
    logic       uniq;
    logic [2:0] idx;
    logic [2:0] nday;
    logic       hit;

    function automatic logic [6:0] glyph(input logic [2:0] d);
        case (d)
            3'd0:    glyph = 7'h70;
            3'd1:    glyph = 7'h40;
            3'd2:    glyph = 7'h3C;
            3'd3:    glyph = 7'h40;
            3'd4:    glyph = 7'h05;
            3'd5:    glyph = 7'h77;
            3'd6:    glyph = 7'h3E;
            default: glyph = 7'h00;
        endcase
    endfunction

    // 7'h40 is known but ambiguous, so it never yields an index on its own
    always_comb begin
        known = 1'b1;
        uniq  = 1'b1;
        idx   = 3'd0;
        case (cand)
            7'h70:   idx = 3'd0;
            7'h3C:   idx = 3'd2;
            7'h05:   idx = 3'd4;
            7'h77:   idx = 3'd5;
            7'h3E:   idx = 3'd6;
            7'h40:   uniq = 1'b0;
            default: begin
                known = 1'b0;
                uniq  = 1'b0;
            end
        endcase
    end

    assign acc  = (cnt == STABLE) && (cand != last_sym);
    assign nday = (day == 3'd6) ? 3'd0 : day + 3'd1;
    assign hit  = (cand == glyph(nday));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            seg_q      <= '0;
            cand       <= '0;
            last_sym   <= '0;
            cnt        <= '0;
            match      <= '0;
            sym_strobe <= 1'b0;
            day        <= '0;
            day_valid  <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            seg_q <= seg;
            if (seg_q != cand) begin
                cand <= seg_q;
                cnt  <= 4'd1;
            end else if (cnt != STABLE) begin
                cnt <= cnt + 4'd1;
            end
            sym_strobe <= 1'b0;
            err        <= 1'b0;
            if (acc) begin
                last_sym   <= cand;
                sym_strobe <= 1'b1;
                if (state == HUNT) begin
                    if (uniq) begin
                        day       <= idx;
                        day_valid <= 1'b1;
                        match     <= '0;
                        state     <= TRACK;
                    end else if (!known) begin
                        err <= 1'b1;
                    end
                end else if (hit) begin
                    day <= nday;
                    if (state == TRACK) begin
                        match <= match + 3'd1;
                        if (match + 3'd1 == LOCKN) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end else begin
                    err    <= 1'b1;
                    locked <= 1'b0;
                    match  <= '0;
                    if (uniq) begin
                        day       <= idx;
                        day_valid <= 1'b1;
                        state     <= TRACK;
                    end else begin
                        day_valid <= 1'b0;
                        state     <= HUNT;
                    end
                end
            end
        end
    end

`ifdef SEG_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_day_decoder.sv
// Directed bench for seg_day_decoder: latency, sequence decode, lock, glitch, errors, reset.
module tb_seg_day_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic       sym_strobe;
    logic [2:0] day;
    logic       day_valid;
    logic       locked;
    logic       err;
`ifdef SEG_DEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int errors = 0;
    int checks = 0;
    int nstb;
    int nerr;
    int both;
    int lat;

    seg_day_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .sym_strobe (sym_strobe),
        .day        (day),
        .day_valid  (day_valid),
        .locked     (locked),
        .err        (err)
`ifdef SEG_DEC_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive p at a negedge and observe n following cycles
    task automatic hold(input logic [6:0] p, input int n);
        seg  = p;
        nstb = 0;
        nerr = 0;
        both = 0;
        repeat (n) begin
            @(negedge clk);
            if (sym_strobe) nstb++;
            if (err) nerr++;
            if (sym_strobe && err) both++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        seg   = 7'($urandom);
        repeat (3) begin
            @(negedge clk);
            seg = 7'($urandom);
        end
        check("rst_strobe", sym_strobe, 0);
        check("rst_day", day, 0);
        check("rst_valid", day_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);

        seg   = 7'h70;
        rst_n = 1'b1;
        lat   = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sym_strobe && lat == 0) lat = k;
        end
        check("mon_latency", lat, 5);
        check("mon_day", day, 0);
        check("mon_valid", day_valid, 1);
        check("mon_locked", locked, 0);

        hold(7'h40, 8);
        check("tue_day", day, 1);
        check("tue_stb", nstb, 1);
        check("tue_locked", locked, 0);
        hold(7'h3C, 8);
        check("wed_day", day, 2);
        check("wed_locked", locked, 1);
        hold(7'h40, 8);
        check("thu_day", day, 3);
        hold(7'h05, 8);
        check("fri_day", day, 4);
        hold(7'h77, 8);
        check("sat_day", day, 5);
        hold(7'h3E, 8);
        check("sun_day", day, 6);
        check("sun_err", nerr, 0);
        hold(7'h70, 8);
        check("wrap_day", day, 0);
        check("wrap_locked", locked, 1);

        hold(7'h40, 8);
        hold(7'h3C, 8);
        check("relock_day", day, 2);
        hold(7'h77, 2);
        check("glitch_stb", nstb, 0);
        hold(7'h3C, 8);
        check("glitch_stb2", nstb, 0);
        check("glitch_err", nerr, 0);
        check("glitch_day", day, 2);
        check("glitch_locked", locked, 1);

        hold(7'h05, 8);
        check("ooo_both", both, 1);
        check("ooo_locked", locked, 0);
        check("ooo_day", day, 4);
        check("ooo_valid", day_valid, 1);
        hold(7'h77, 8);
        check("ooo_track_day", day, 5);
        check("ooo_track_err", nerr, 0);

        hold(7'h7F, 20);
        check("unk_err_once", nerr, 1);
        check("unk_valid", day_valid, 0);

        hold(7'h7E, 5);
        check("unk2_err", err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_err", err, 0);
        check("arst_strobe", sym_strobe, 0);
        check("arst_day", day, 0);
        check("arst_valid", day_valid, 0);
        check("arst_locked", locked, 0);

        @(negedge clk);
        rst_n = 1'b1;
        hold(7'h40, 12);
        check("amb_valid", day_valid, 0);
        check("amb_locked", locked, 0);
        check("amb_err", nerr, 0);
        hold(7'h3C, 8);
        check("amb_wed_day", day, 2);
        check("amb_wed_valid", day_valid, 1);

`ifdef SEG_DEC_ERRCNT_EN
        for (int i = 0; i < 150; i++) begin
            hold(7'h7F, 6);
            hold(7'h7E, 6);
        end
        repeat (2) @(negedge clk);
        check("errcnt_sat", err_count, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
